// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: RISC-V immediate generator feeding a small result FIFO.
// Each accepted request decodes in_inst/in_sel into an XLEN-bit immediate.
// The immediate is stored together with in_tag and an error bit.
// Results drain in order through a valid/ready output port.
//
// Ports:
//   clk, rst_n         clock, synchronous active-low reset
//   flush              synchronous buffer clear (rst_n has priority)
//   in_valid/in_ready  request handshake; in_sel, in_inst, in_tag payload
//   out_valid/out_ready head-of-buffer handshake
//   out_imm, out_tag, out_err  head entry (held when the buffer is empty)
//   count              current buffer occupancy
//
// Build option: define IMM_GEN_CSR_EN to decode sel 110 as a CSR zimm
// (inst[19:15], zero-extended). Otherwise sel 110 is flagged as an error.
module imm_gen_pipe #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned DEPTH = 2,
   parameter int unsigned TAG_W = 32
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       flush,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [2:0]                 in_sel,
   input  logic [31:0]                in_inst,
   input  logic [TAG_W-1:0]           in_tag,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [XLEN-1:0]            out_imm,
   output logic [TAG_W-1:0]           out_tag,
   output logic                       out_err,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam int unsigned ENT_W = XLEN + TAG_W + 1;

   logic [ENT_W-1:0] mem [DEPTH];

   logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
   logic [CNT_W-1:0] cnt_q, cnt_d, cnt_rem;
   logic [ENT_W-1:0] head_q, head_d;
   logic             in_ready_q, out_valid_q;

   logic [XLEN-1:0]  imm_c;
   logic             err_c;
   logic [ENT_W-1:0] new_ent;
   logic             push, pop;

   // Immediate decode of the incoming instruction word
   always_comb begin
      imm_c = XLEN'($signed(in_inst[31:20]));
      err_c = 1'b0;
      case (in_sel)
         3'b000: imm_c = XLEN'($signed(in_inst[31:20]));
         3'b001: imm_c = XLEN'($signed({in_inst[31:25], in_inst[11:7]}));
         3'b010: imm_c = XLEN'($signed({in_inst[31:12], 12'b0}));
         3'b011: imm_c = XLEN'($signed({in_inst[31], in_inst[19:12],
                                        in_inst[20], in_inst[30:21], 1'b0}));
         3'b100: imm_c = XLEN'($signed({in_inst[31], in_inst[7],
                                        in_inst[30:25], in_inst[11:8], 1'b0}));
         3'b101: imm_c = XLEN'(in_inst[31:20]);
`ifdef IMM_GEN_CSR_EN
         3'b110: imm_c = XLEN'(in_inst[19:15]);
`else
         3'b110: err_c = 1'b1;
`endif
         default: err_c = 1'b1;
      endcase
   end

   assign new_ent = {imm_c, in_tag, err_c};
   assign push    = in_valid && in_ready_q;
   assign pop     = out_valid_q && out_ready;

   // Next-state: pointers, occupancy and the registered head copy
   always_comb begin
      wr_d    = wr_q;
      rd_d    = rd_q;
      cnt_d   = cnt_q;
      head_d  = head_q;
      cnt_rem = cnt_q - CNT_W'(pop);
      if (flush) begin
         wr_d  = '0;
         rd_d  = '0;
         cnt_d = '0;
      end else begin
         wr_d  = wr_q + PTR_W'(push);
         rd_d  = rd_q + PTR_W'(pop);
         cnt_d = cnt_rem + CNT_W'(push);
         // Head after the edge: an older entry if one remains, otherwise
         // the entry being written now; empty buffer holds the last head.
         if (cnt_rem != '0) begin
            head_d = mem[rd_d];
         end else if (push) begin
            head_d = new_ent;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_q        <= '0;
         rd_q        <= '0;
         cnt_q       <= '0;
         head_q      <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         wr_q        <= wr_d;
         rd_q        <= rd_d;
         cnt_q       <= cnt_d;
         head_q      <= head_d;
         in_ready_q  <= (cnt_d < CNT_W'(DEPTH));
         out_valid_q <= (cnt_d != '0);
      end
   end

   // Storage array; no reset needed since pointers gate visibility
   always_ff @(posedge clk) begin
      if (rst_n && !flush && push) begin
         mem[wr_q] <= new_ent;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign count     = cnt_q;
   assign out_imm   = head_q[ENT_W-1 -: XLEN];
   assign out_tag   = head_q[TAG_W:1];
   assign out_err   = head_q[0];

endmodule
